// File: rtl/cpu_garage_pkg.sv
// ---------------------------------------------------------------------------
// cpu_garage_pkg
// Definitions shared by the cpu_garage core, its data RAM and the
// data-memory write logger.
//   ADDR_W / DATA_W : data-memory address and word widths
//   SEQ_W           : width of the write-log sequence number
//   DROP_W          : width of the saturating dropped-write counter
//   wr_log_t        : one trace entry {addr, data, seq}
//   sat_inc()       : increment that sticks at all-ones
// ---------------------------------------------------------------------------
package cpu_garage_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;
    localparam int SEQ_W  = 16;
    localparam int DROP_W = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [SEQ_W-1:0]  seq;
    } wr_log_t;

    localparam int WR_LOG_W = $bits(wr_log_t);

    // Counter increment that holds at the maximum instead of wrapping.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        if (v == {DROP_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(DROP_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/dmem_write_logger_if.sv
// ---------------------------------------------------------------------------
// dmem_write_logger_if
// Bundles the CPU data-memory write port seen by the logger and the trace
// stream it produces.
//   we, ram_address, cpu_out_m : CPU write strobe, address, data
//   log_valid / log_ready      : head-entry handshake
//   log_addr, log_data, log_seq: head entry fields
//   level                      : FIFO occupancy
//   drop_cnt                   : saturating count of writes lost to a full FIFO
// Modports:
//   master : environment side (drives the CPU write and log_ready)
//   slave  : logger side
// ---------------------------------------------------------------------------
interface dmem_write_logger_if #(
    parameter int DEPTH = 16
);
    import cpu_garage_pkg::*;

    logic                   we;
    logic [ADDR_W-1:0]      ram_address;
    logic [DATA_W-1:0]      cpu_out_m;
    logic                   log_valid;
    logic                   log_ready;
    logic [ADDR_W-1:0]      log_addr;
    logic [DATA_W-1:0]      log_data;
    logic [SEQ_W-1:0]       log_seq;
    logic [$clog2(DEPTH):0] level;
    logic [DROP_W-1:0]      drop_cnt;

    modport master (
        output we, ram_address, cpu_out_m, log_ready,
        input  log_valid, log_addr, log_data, log_seq, level, drop_cnt
    );

    modport slave (
        input  we, ram_address, cpu_out_m, log_ready,
        output log_valid, log_addr, log_data, log_seq, level, drop_cnt
    );

endinterface

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Generic single-clock FIFO with a register-array store read at the read
// pointer (no output register, no bypass).
//   Clk, Reset : rising-edge clock, synchronous active-high reset
//   push_i     : store wr_data_i (accepted when not full, or full with a pop)
//   pop_i      : discard the head entry (ignored when empty)
//   wr_data_i  : entry to store
//   rd_data_o  : head entry
//   full_o     : DEPTH entries stored
//   empty_o    : no entries stored
//   level_o    : occupancy, 0..DEPTH
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                       (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign level_o   = wr_ptr_q - rd_ptr_q;
    assign rd_data_o = mem_q[rd_ptr_q[IDX_W-1:0]];

    // Qualify push/pop and compute next pointer values.
    always_comb begin
        do_pop_s  = pop_i && !empty_o;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        do_push_s = push_i && (!full_o || do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge Clk) begin
        if (do_push_s && !Reset) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/dmem_write_logger.sv
// ---------------------------------------------------------------------------
// dmem_write_logger
// Traces every qualified CPU data-memory write into a FIFO that drains over a
// valid/ready handshake. Each entry carries a sequence number that advances on
// every qualified write, stored or dropped, so the consumer can spot losses.
// The CPU is never back-pressured.
//   Clk, Reset : rising-edge clock, synchronous active-high reset
//   bus        : write port in, trace stream out (see dmem_write_logger_if)
// Parameters:
//   DEPTH          : FIFO entries, power of two, at least 2
//   WIN_LO, WIN_HI : inclusive address window that is captured
// ---------------------------------------------------------------------------
module dmem_write_logger
    import cpu_garage_pkg::*;
#(
    parameter int                DEPTH  = 16,
    parameter logic [ADDR_W-1:0] WIN_LO = '0,
    parameter logic [ADDR_W-1:0] WIN_HI = '1
) (
    input  logic              Clk,
    input  logic              Reset,
    dmem_write_logger_if.slave bus
);

    logic              lo_ok_s;
    logic              hi_ok_s;
    logic              qual_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;
    logic              full_s;
    logic              empty_s;
    wr_log_t           wr_entry_s;
    wr_log_t           rd_entry_s;
    wr_log_t           head_s;
    wr_log_t           hold_q;
    wr_log_t           hold_d;
    logic [SEQ_W-1:0]  seq_q;
    logic [SEQ_W-1:0]  seq_d;
    logic [DROP_W-1:0] drop_q;
    logic [DROP_W-1:0] drop_d;

    // An open window edge needs no comparator (and would compare against a
    // constant that is always true).
    generate
        if (WIN_LO == {ADDR_W{1'b0}}) begin : g_lo_open
            assign lo_ok_s = 1'b1;
        end else begin : g_lo_cmp
            assign lo_ok_s = (bus.ram_address >= WIN_LO);
        end
        if (WIN_HI == {ADDR_W{1'b1}}) begin : g_hi_open
            assign hi_ok_s = 1'b1;
        end else begin : g_hi_cmp
            assign hi_ok_s = (bus.ram_address <= WIN_HI);
        end
    endgenerate

    assign qual_s = bus.we && lo_ok_s && hi_ok_s;
    assign pop_s  = bus.log_valid && bus.log_ready;
    assign push_s = qual_s && (!full_s || pop_s);
    assign drop_s = qual_s && full_s && !pop_s;

    assign wr_entry_s = '{addr: bus.ram_address, data: bus.cpu_out_m, seq: seq_q};

    sync_fifo #(
        .WIDTH (WR_LOG_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk       (Clk),
        .Reset     (Reset),
        .push_i    (push_s),
        .pop_i     (pop_s),
        .wr_data_i (wr_entry_s),
        .rd_data_o (rd_entry_s),
        .full_o    (full_s),
        .empty_o   (empty_s),
        .level_o   (bus.level)
    );

    // While empty the outputs show the last popped entry rather than a stale slot.
    assign head_s        = empty_s ? hold_q : rd_entry_s;
    assign bus.log_valid = !empty_s;
    assign bus.log_addr  = head_s.addr;
    assign bus.log_data  = head_s.data;
    assign bus.log_seq   = head_s.seq;
    assign bus.drop_cnt  = drop_q;

    // Next-state for sequence number, drop counter and held head entry.
    always_comb begin
        seq_d  = seq_q;
        drop_d = drop_q;
        hold_d = hold_q;
        if (qual_s) begin
            seq_d = seq_q + SEQ_W'(1'b1);
        end else begin
            seq_d = seq_q;
        end
        if (drop_s) begin
            drop_d = sat_inc(drop_q);
        end else begin
            drop_d = drop_q;
        end
        if (pop_s) begin
            hold_d = rd_entry_s;
        end else begin
            hold_d = hold_q;
        end
    end

    // Counter and held-entry registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            seq_q  <= '0;
            drop_q <= '0;
            hold_q <= '0;
        end else begin
            seq_q  <= seq_d;
            drop_q <= drop_d;
            hold_q <= hold_d;
        end
    end

endmodule

// File: doc/dmem_write_logger.md
# dmem_write_logger

Captures every qualified CPU data-memory write (the `we` / `ram_address` / `cpu_out_m` bundle leaving the cpu_garage core) into an on-chip trace FIFO. Entries drain in order to a downstream consumer over a valid/ready handshake, such as a UART bridge or a debug-bus reader. The block is the hardware equivalent of the simulation write tracker: each entry carries a sequence number so the consumer can detect dropped writes. It sits beside the RAM on the core's write port and never back-pressures the CPU.

## Interface
- `ADDR_W`, 15: data-memory address width.
- `DATA_W`, 16: data word width.
- `DEPTH`, 16: FIFO entries; must be a power of 2, ≥ 2.
- `SEQ_W`, 16: sequence-number width.
- `WIN_LO`, 0: lowest address captured (inclusive).
- `WIN_HI`, 2^ADDR_W−1: highest address captured (inclusive).

Ports:
- `Clk`, in, 1: single clock. All logic is on its rising edge.
- `Reset`, in, 1: synchronous, active-high reset.
- `we`, in, 1: CPU data-memory write strobe for the current cycle.
- `ram_address`, in, ADDR_W: write address.
- `cpu_out_m`, in, DATA_W: write data.
- `log_valid`, out, 1: the head entry is presented.
- `log_ready`, in, 1: the consumer accepts the head entry.
- `log_addr`, out, ADDR_W: head entry address.
- `log_data`, out, DATA_W: head entry data.
- `log_seq`, out, SEQ_W: head entry sequence number.
- `level`, out, $clog2(DEPTH)+1: current FIFO occupancy.
- `drop_cnt`, out, 16: saturating count of writes lost because the FIFO was full.

## Operation
- **Qualified write:** `we`=1 and WIN_LO ≤ `ram_address` ≤ WIN_HI, sampled at the rising edge.
- **Sequence counter:**
  - Increments by 1 on every qualified write, whether stored or dropped.
  - Wraps modulo 2^SEQ_W.
  - The stored entry carries the pre-increment value, so the first write after reset has seq 0.
- **Push:** a qualified write with the FIFO not full, or full with a pop in the same cycle, stores {addr, data, seq}.
- **Drop:** a qualified write with the FIFO full and no pop in that cycle.
  - Nothing is stored.
  - `drop_cnt` increments and saturates at 16'hFFFF.
  - The sequence counter still increments, so the gap is visible downstream.
- **Pop:** occurs when `log_valid` && `log_ready`. The head advances at the edge.
- **Simultaneous push and pop:**
  - Allowed at any occupancy, including full.
  - `level` is unchanged.
  - No drop occurs when full.
- **Empty:** `log_valid`=0. `log_addr`, `log_data` and `log_seq` hold their last values; they are don't-care to the consumer.
- **No bypass:** a write pushed into an empty FIFO is not visible in the same cycle.
- **Pointers:** read and write pointers are $clog2(DEPTH)+1 bits wide and wrap naturally.
  - Full when the MSBs differ and the low bits are equal.
  - Empty when the pointers are equal.
- **Non-qualified writes:** `we`=0 cycles and out-of-window addresses have no effect on any state.

## Timing
- **Reset (synchronous):** pointers, `level`, the sequence counter and `drop_cnt` clear to 0. `log_valid`=0, and `log_addr`, `log_data` and `log_seq` = 0. The reset takes effect at the first rising edge with `Reset`=1.
- **Reset mid-operation:** flushes all stored entries. A write or pop in the reset cycle is ignored.
- **Capture latency:**
  - A write at edge N appears on `log_*` with `log_valid`=1 after edge N when the FIFO was empty.
  - It is therefore visible in cycle N+1 and can be popped at edge N+1.
- **Throughput:** one push and one pop per cycle, sustained.
- **Outputs:** `log_valid`, `level` and `drop_cnt` are registered or pure register decodes. `log_ready` has no combinational path to any output except through a clock edge.
- **Handshake rules:**
  - Once `log_valid`=1, the head entry stays stable until it is popped.
  - `log_valid` never drops without a pop, except on reset.
  - The consumer may hold `log_ready` high continuously.

## Structure
- **Package `cpu_garage_pkg`:**
  - Shared ADDR_W/DATA_W localparams used by the core and the RAM.
  - `typedef struct packed {addr; data; seq;} wr_log_t`.
- **Sub-module `sync_fifo`:**
  - Parameterised on width and DEPTH, with `Clk`/`Reset`, push/pop, full/empty and level.
  - Storage is a register array; reading is by indexing at the read pointer.
  - It is generic so that other trace stages can reuse it.
- **Top level:** the window comparator, sequence counter, drop counter and the `wr_log_t` pack/unpack.

## Test plan
1. **Single capture:** after reset, `we`=1, addr 15'h0010, data 16'hBEEF for one cycle, `log_ready`=0.
   - Next cycle: `log_valid`=1, `log_addr`=0010, `log_data`=BEEF, `log_seq`=0, `level`=1.
   - Raise `log_ready` for one cycle, then `level`=0 and `log_valid`=0.
2. **Window filter:** WIN_LO=16, WIN_HI=31; writes to addresses 15, 16, 31 and 32.
   - Only 16 and 31 are logged, with seq 0 and 1.
   - Writes with `we`=0 to address 20 are ignored.
3. **Overflow:** `log_ready`=0, with 18 consecutive qualified writes carrying data 0..17 (DEPTH 16).
   - Result: `level`=16 and `drop_cnt`=2.
   - Draining yields data 0..15 with seq 0..15.
   - The next write is logged with seq 18.
4. **Full with simultaneous push and pop:** FIFO full, `we`=1 and `log_ready`=1 in the same cycle.
   - `level` stays 16 and `drop_cnt` is unchanged.
   - The new entry appears last in drain order.
5. **Streaming:** `log_ready`=1 and `we`=1 every cycle for 100 cycles.
   - `level` toggles at most between 0 and 1.
   - 100 entries arrive with seq 0..99 in order and `drop_cnt`=0.
6. **Reset mid-operation:** with 5 entries queued, assert `Reset` for one cycle while `we`=1.
   - `level`=0, `log_valid`=0 and `drop_cnt`=0.
   - The next write is logged with seq 0.
